// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the parametrised shift-register counter.
// Imported by the decoder and the top level.
package shift_counter_pkg;

   localparam int MODE_JOHNSON = 0;
   localparam int MODE_RING    = 1;

   // Reset pattern: Johnson starts all-zeros, ring starts with bit 0 set.
   function automatic logic [31:0] rst_state(input int width, input int mode);
      logic [31:0] s;
      s    = '0;
      s[0] = (mode == MODE_RING) && (width > 0);
      return s;
   endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and phase decode of the counter register.
// phase counts forward steps from the reset state; it reads 0 for illegal states.
module shift_counter_decode
   import shift_counter_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int MODE  = MODE_JOHNSON,
   localparam int NST   = (MODE == MODE_JOHNSON) ? 2*WIDTH : WIDTH,
   localparam int PHW   = $clog2(NST)
) (
   input  logic [WIDTH-1:0] Q,
   output logic             legal,
   output logic [PHW-1:0]   phase
);

   int ones;
   int trans;
   int hot;

   // NOTE: every output and temporary gets a default first so no path
   // through the block leaves a value unassigned (no latch inferred).
   always_comb begin
      legal = 1'b0;
      phase = '0;
      ones  = 0;
      trans = 0;
      hot   = 0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + int'(Q[i]);
         if (Q[i]) hot = i;
      end
      for (int i = 0; i < WIDTH-1; i++) begin
         trans = trans + int'(Q[i] ^ Q[i+1]);
      end

      if (MODE == MODE_JOHNSON) begin
         legal = (trans <= 1);
         // Forward fills ones from the MSB, then drains them from the MSB.
         if (legal) begin
            if (Q[WIDTH-1] || ones == 0) phase = PHW'(ones);
            else                         phase = PHW'(NST - ones);
         end
      end else begin
         legal = (ones == 1);
         if (legal && hot != 0) phase = PHW'(WIDTH - hot);
      end
   end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson / one-hot ring counter with enable, direction, clear,
// load, illegal-state self-correction, phase decode and wrap/err pulses.
module shift_counter_gen
   import shift_counter_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int MODE  = MODE_JOHNSON,
   localparam int NST   = (MODE == MODE_JOHNSON) ? 2*WIDTH : WIDTH,
   localparam int PHW   = $clog2(NST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             sync_clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] Q,
   output logic [PHW-1:0]   phase,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] RST = WIDTH'(rst_state(WIDTH, MODE));

   logic             legal;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] q_step;
   logic             wrap_nxt;
   logic             err_nxt;

   shift_counter_decode #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_decode (
      .Q     (Q),
      .legal (legal),
      .phase (phase)
   );

   // One step in the sampled direction; Johnson inverts the bit it feeds back.
   always_comb begin
      q_step = Q;
      if (MODE == MODE_JOHNSON) begin
         if (!dir) q_step = {~Q[0], Q[WIDTH-1:1]};
         else      q_step = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
      end else begin
         if (!dir) q_step = {Q[0], Q[WIDTH-1:1]};
         else      q_step = {Q[WIDTH-2:0], Q[WIDTH-1]};
      end
   end

   always_comb begin
      q_nxt    = Q;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (sync_clr) begin
         q_nxt = RST;
      end else if (ld) begin
         q_nxt = ld_val;
      end else if (!legal) begin
         q_nxt   = RST;
         err_nxt = 1'b1;
      end else if (en) begin
         q_nxt    = q_step;
         wrap_nxt = dir ? (phase == '0) : (phase == PHW'(NST-1));
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q    <= RST;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         Q    <= q_nxt;
         wrap <= wrap_nxt;
         err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench: a 4-bit Johnson and an 8-bit ring instance checked every
// cycle against a sequence-table reference model, directed then random stimulus.
module tb_shift_counter_gen;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance a: WIDTH=4 Johnson; instance b: WIDTH=8 ring
   logic       a_en, a_dir, a_clr, a_ld, a_wrap, a_err;
   logic [3:0] a_ldv, a_q;
   logic [2:0] a_phase;
   logic       b_en, b_dir, b_clr, b_ld, b_wrap, b_err;
   logic [7:0] b_ldv, b_q;
   logic [2:0] b_phase;

   shift_counter_gen #(.WIDTH(4), .MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(a_en), .dir(a_dir), .sync_clr(a_clr),
      .ld(a_ld), .ld_val(a_ldv), .Q(a_q), .phase(a_phase), .wrap(a_wrap), .err(a_err)
   );

   shift_counter_gen #(.WIDTH(8), .MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(b_en), .dir(b_dir), .sync_clr(b_clr),
      .ld(b_ld), .ld_val(b_ldv), .Q(b_q), .phase(b_phase), .wrap(b_wrap), .err(b_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the legal sequence is tabulated by phase index, and the
   // counter state is a position in that table (or a raw illegal value).
   function automatic logic [31:0] seq_val(input int w, input int m, input int k);
      if (m == 0) begin
         if (k <= w) return ((32'd1 << k) - 1) << (w - k);
         else        return (32'd1 << (2*w - k)) - 1;
      end
      if (k == 0) return 32'd1;
      return 32'd1 << (w - k);
   endfunction

   function automatic int nst_of(input int w, input int m);
      return (m == 0) ? 2*w : w;
   endfunction

   function automatic int find_phase(input int w, input int m, input logic [31:0] q);
      for (int k = 0; k < nst_of(w, m); k++)
         if (seq_val(w, m, k) == q) return k;
      return -1;
   endfunction

   function automatic logic [31:0] exp_phase(input int w, input int m, input logic [31:0] q);
      int p;
      p = find_phase(w, m, q);
      return (p < 0) ? 32'd0 : 32'(p);
   endfunction

   task automatic model_step(input int w, input int m, inout logic [31:0] q,
                             output logic wrap, output logic err,
                             input logic en, input logic dir, input logic clr,
                             input logic ld, input logic [31:0] ldv);
      int p, n;
      p    = find_phase(w, m, q);
      n    = nst_of(w, m);
      wrap = 1'b0;
      err  = 1'b0;
      if (clr)         q = seq_val(w, m, 0);
      else if (ld)     q = ldv & ((32'd1 << w) - 1);
      else if (p < 0) begin
         q   = seq_val(w, m, 0);
         err = 1'b1;
      end else if (en) begin
         if (!dir) begin
            wrap = (p == n-1);
            p    = (p + 1) % n;
         end else begin
            wrap = (p == 0);
            p    = (p + n - 1) % n;
         end
         q = seq_val(w, m, p);
      end
   endtask

   logic [31:0] ma_q, mb_q;
   logic        ma_wrap, ma_err, mb_wrap, mb_err;

   task automatic check_all();
      check("a_q",     32'(a_q),     ma_q);
      check("a_phase", 32'(a_phase), exp_phase(4, 0, ma_q));
      check("a_wrap",  32'(a_wrap),  32'(ma_wrap));
      check("a_err",   32'(a_err),   32'(ma_err));
      check("b_q",     32'(b_q),     mb_q);
      check("b_phase", 32'(b_phase), exp_phase(8, 1, mb_q));
      check("b_wrap",  32'(b_wrap),  32'(mb_wrap));
      check("b_err",   32'(b_err),   32'(mb_err));
   endtask

   // Inputs are set at the falling edge, sampled on the rising edge, and
   // outputs checked at the next falling edge.
   task automatic tick();
      @(posedge clk);
      model_step(4, 0, ma_q, ma_wrap, ma_err, a_en, a_dir, a_clr, a_ld, 32'(a_ldv));
      model_step(8, 1, mb_q, mb_wrap, mb_err, b_en, b_dir, b_clr, b_ld, 32'(b_ldv));
      @(negedge clk);
      check_all();
   endtask

   task automatic set_a(input logic en, input logic dir, input logic clr,
                        input logic ld, input logic [3:0] ldv);
      a_en = en; a_dir = dir; a_clr = clr; a_ld = ld; a_ldv = ldv;
   endtask

   task automatic set_b(input logic en, input logic dir, input logic clr,
                        input logic ld, input logic [7:0] ldv);
      b_en = en; b_dir = dir; b_clr = clr; b_ld = ld; b_ldv = ldv;
   endtask

   task automatic model_reset();
      ma_q = 32'h0; mb_q = 32'h1;
      ma_wrap = 1'b0; ma_err = 1'b0; mb_wrap = 1'b0; mb_err = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      set_a(0, 0, 0, 0, 4'h0);
      set_b(0, 0, 0, 0, 8'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // Forward full Johnson cycle and 8-step ring cycle, wrap on the last step
      set_a(1, 0, 0, 0, 4'h0);
      set_b(1, 0, 0, 0, 8'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) check("a_first_step", 32'(a_q), 32'h8);
         if (i == 1) check("b_second_step", 32'(b_q), 32'h40);
      end
      check("a_wrap_fwd", 32'(a_wrap), 32'h1);
      check("b_wrap_fwd", 32'(b_wrap), 32'h1);

      // Reverse from reset state: wraps to phase NST-1
      set_a(1, 1, 0, 0, 4'h0);
      set_b(1, 1, 0, 0, 8'h0);
      tick();
      check("a_rev_q", 32'(a_q), 32'h1);
      check("a_rev_phase", 32'(a_phase), 32'd7);
      check("a_rev_wrap", 32'(a_wrap), 32'h1);
      tick();
      check("a_rev_q2", 32'(a_q), 32'h3);
      set_a(0, 1, 0, 0, 4'h0);
      set_b(0, 1, 0, 0, 8'h0);
      tick();
      check("a_hold_q", 32'(a_q), 32'h3);

      // Illegal load, corrected on the following edge despite en
      set_a(0, 0, 0, 1, 4'b1010);
      set_b(0, 0, 0, 1, 8'b0000_0011);
      tick();
      check("a_ld_phase", 32'(a_phase), 32'h0);
      set_a(1, 0, 0, 0, 4'h0);
      set_b(1, 0, 0, 0, 8'h0);
      tick();
      check("a_corr_err", 32'(a_err), 32'h1);
      check("b_corr_q", 32'(b_q), 32'h1);
      tick();
      tick();
      tick();
      check("a_at_1110", 32'(a_q), 32'hE);

      // Clear beats load beats enable
      set_a(1, 0, 1, 1, 4'hF);
      tick();
      check("a_clr_wins", 32'(a_q), 32'h0);
      set_a(1, 0, 0, 1, 4'b0011);
      tick();
      check("a_ld_wins", 32'(a_q), 32'h3);
      set_a(1, 1, 0, 0, 4'h0);
      set_b(0, 0, 0, 1, 8'b0000_0011);
      tick();
      set_b(0, 0, 0, 0, 8'h0);
      tick();
      check("a_at_1111", 32'(a_q), 32'hF);

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_a_q", 32'(a_q), 32'h0);
      check("rst_a_err", 32'({a_wrap, a_err}), 32'h0);
      check("rst_b_q", 32'(b_q), 32'h1);
      check("rst_b_err", 32'({b_wrap, b_err}), 32'h0);
      #1 rst_n = 1'b1;
      set_a(1, 0, 0, 0, 4'h0);
      tick();
      check("a_resume", 32'(a_q), 32'h8);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_a(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
               ($urandom % 10) == 0, 4'($urandom));
         set_b(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
               ($urandom % 10) == 0, 8'($urandom));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
